// File: rtl/sram_pkg.sv
// Shared widths and word/address types for the register-based SRAM.
// Imported by the storage core, its read pipeline and the bench.
package sram_pkg;

    localparam int SRAM_ADDR_W = 4;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_DEPTH  = 2 ** SRAM_ADDR_W;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
    typedef logic [SRAM_DATA_W-1:0] sram_word_t;

endpackage

// File: rtl/sram_rd_pipe.sv
// One-stage read request register for sram_core.
// A read accepted at edge N is presented as {rd_v, addr_q} for edge N+1.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    output logic              rd_v,
    output logic [ADDR_W-1:0] addr_q
);

    // A simultaneous write drops the read request entirely.
    logic take;
    assign take = re & ~we;

    // Capture the request; reset discards any read still in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_v   <= 1'b0;
            addr_q <= '0;
        end else begin
            rd_v <= take;
            if (take) begin
                addr_q <= addr;
            end
        end
    end

endmodule

// File: rtl/sram_core.sv
// Single-port flop-based SRAM with write-through and a registered output.
// Read data appears one edge after the request edge is registered.
module sram_core
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_dataIn,
    input  logic              io_en_we,
    input  logic              io_en_re,
    output logic [DATA_W-1:0] io_dataOut
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_v;
    logic [ADDR_W-1:0] addr_q;

    sram_rd_pipe #(
        .ADDR_W (ADDR_W)
    ) u_rd_pipe (
        .clock  (clock),
        .reset  (reset),
        .we     (io_en_we),
        .re     (io_en_re),
        .addr   (io_addr),
        .rd_v   (rd_v),
        .addr_q (addr_q)
    );

    // Storage array: cleared on reset, written on we.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (io_en_we) begin
            mem[io_addr] <= io_dataIn;
        end
    end

    // Output register: reset > write-through > pending read > hold.
    // mem[addr_q] is the pre-write value, so a colliding write wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_dataOut <= '0;
        end else if (io_en_we) begin
            io_dataOut <= io_dataIn;
        end else if (rd_v) begin
            io_dataOut <= mem[addr_q];
        end
    end

endmodule

// File: tb/tb_sram_core.sv
// Directed bench for sram_core: write-through, read latency,
// pipelined reads, we/re collision, write-after-read and mid-read reset.
module tb_sram_core;
    import sram_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    sram_addr_t io_addr;
    sram_word_t io_dataIn;
    logic       io_en_we;
    logic       io_en_re;
    sram_word_t io_dataOut;

    int total  = 0;
    int passed = 0;

    sram_core dut (
        .clock      (clock),
        .reset      (reset),
        .io_addr    (io_addr),
        .io_dataIn  (io_dataIn),
        .io_en_we   (io_en_we),
        .io_en_re   (io_en_re),
        .io_dataOut (io_dataOut)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic we, input logic re,
                        input sram_addr_t a, input sram_word_t d);
        reset     = rst;
        io_en_we  = we;
        io_en_re  = re;
        io_addr   = a;
        io_dataIn = d;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input sram_word_t exp);
        total++;
        assert (io_dataOut === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, io_dataOut, exp);
    endtask

    initial begin
        reset = 1'b1; io_en_we = 1'b0; io_en_re = 1'b0;
        io_addr = '0; io_dataIn = '0;
        @(negedge clock);

        // 1: reset, then read of an arbitrary address
        step(1, 0, 0, 4'h0, 16'h0000);
        chk("reset_out", 16'h0000);
        step(0, 0, 1, 4'h5, 16'h0000);
        chk("rd5_issue", 16'h0000);
        step(0, 0, 0, 4'h0, 16'h0000);
        chk("rd5_data", 16'h0000);

        // 2: writes with write-through, then read latency
        step(0, 1, 0, 4'h0, 16'h1234);
        chk("wr0_thru", 16'h1234);
        step(0, 1, 0, 4'h1, 16'hABCD);
        chk("wr1_thru", 16'hABCD);
        step(0, 0, 1, 4'h0, 16'h0000);
        chk("rd0_issue", 16'hABCD);
        step(0, 0, 0, 4'h0, 16'h0000);
        chk("rd0_data", 16'h1234);
        step(0, 0, 0, 4'h0, 16'h0000);
        chk("idle_hold", 16'h1234);

        // 3: back-to-back reads 1,0,1
        step(0, 0, 1, 4'h1, 16'h0000);
        chk("b2b_issue", 16'h1234);
        step(0, 0, 1, 4'h0, 16'h0000);
        chk("b2b_a1", 16'hABCD);
        step(0, 0, 1, 4'h1, 16'h0000);
        chk("b2b_a0", 16'h1234);
        step(0, 0, 0, 4'h0, 16'h0000);
        chk("b2b_a1b", 16'hABCD);

        // 4: we and re together at addr2
        step(0, 1, 1, 4'h2, 16'h5A5A);
        chk("wr_rd_thru", 16'h5A5A);
        step(0, 0, 0, 4'h0, 16'h0000);
        chk("wr_rd_norddata", 16'h5A5A);
        step(0, 0, 1, 4'h0, 16'h0000);
        chk("rd0_issue2", 16'h5A5A);
        step(0, 0, 1, 4'h2, 16'h0000);
        chk("rd0_data2", 16'h1234);
        step(0, 0, 0, 4'h0, 16'h0000);
        chk("rd2_data", 16'h5A5A);

        // 5: read addr3, colliding write to addr3 on the next edge
        step(0, 0, 1, 4'h3, 16'h0000);
        chk("rd3_issue", 16'h5A5A);
        step(0, 1, 0, 4'h3, 16'hFFFF);
        chk("rd3_wr_wins", 16'hFFFF);
        step(0, 0, 1, 4'h0, 16'h0000);
        chk("rd0_issue3", 16'hFFFF);
        step(0, 0, 1, 4'h3, 16'h0000);
        chk("rd0_data3", 16'h1234);
        step(0, 0, 0, 4'h0, 16'h0000);
        chk("rd3_data", 16'hFFFF);

        // 6: reset while a read is in flight
        step(0, 0, 1, 4'h1, 16'h0000);
        chk("rd1_issue", 16'hFFFF);
        step(1, 0, 0, 4'h0, 16'h0000);
        chk("mid_reset", 16'h0000);
        step(0, 0, 0, 4'h0, 16'h0000);
        chk("no_stale", 16'h0000);
        step(0, 0, 1, 4'h0, 16'h0000);
        for (int i = 1; i < SRAM_DEPTH; i++) begin
            step(0, 0, 1, sram_addr_t'(i), 16'h0000);
            chk($sformatf("clr_%0d", i - 1), 16'h0000);
        end
        step(0, 0, 0, 4'h0, 16'h0000);
        chk("clr_15", 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
